// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : register-file write-port arbiter (src 0 fixed priority,
//                   src 1..N-1 round-robin, bounded starvation of src>0)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic [NUM_SRC-1:0]      src_valid_i,
  input  logic [NUM_SRC*5-1:0]    src_rd_i,
  input  logic [NUM_SRC*64-1:0]   src_data_i,
  output logic [NUM_SRC-1:0]      src_ready_o,
  output logic                    rf_wr_en_o,
  output logic [4:0]              rf_wr_addr_o,
  output logic [63:0]             rf_wr_data_o
);

  localparam int PTR_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [4:0]         wr_addr_q, wr_addr_d;
  logic [63:0]        wr_data_q, wr_data_d;

  logic               any_hi;
  logic               starved;
  logic               rr_hit;
  logic [PTR_W-1:0]   rr_idx;
  logic [NUM_SRC-1:0] grant;
  logic               hi_granted;
  logic               xfer;
  logic [4:0]         sel_rd;
  logic [63:0]        sel_data;

  assign any_hi  = |src_valid_i[NUM_SRC-1:1];
  assign starved = (wait_cnt_q == CNT_MAX);

  // Round-robin pick among src>0: offset i from rr_ptr, wrapping NUM_SRC-1 -> 1.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = PTR_FIRST;
    for (int i = 0; i < NUM_SRC - 1; i++) begin
      for (int k = 1; k < NUM_SRC; k++) begin
        if (!rr_hit && src_valid_i[k] &&
            ((int'(rr_ptr_q) + i == k) || (int'(rr_ptr_q) + i == k + NUM_SRC - 1))) begin
          rr_hit = 1'b1;
          rr_idx = PTR_W'(k);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (resetn_i) begin
      if (rr_hit && (starved || !src_valid_i[0])) begin
        grant[rr_idx] = 1'b1;
      end else if (src_valid_i[0]) begin
        grant[0] = 1'b1;
      end
    end
  end

  assign src_ready_o = grant;
  assign hi_granted  = |grant[NUM_SRC-1:1];
  assign xfer        = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant[k]) begin
        sel_rd   = src_rd_i[5*k +: 5];
        sel_data = src_data_i[64*k +: 64];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    if (hi_granted) begin
      rr_ptr_d   = (rr_idx == PTR_LAST) ? PTR_FIRST : rr_idx + PTR_W'(1);
      wait_cnt_d = '0;
    end else if (grant[0] && any_hi) begin
      wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end else if (!any_hi) begin
      wait_cnt_d = '0;
    end
  end

  // x0 writes still complete the handshake but never assert the write enable.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_en_d   = (sel_rd != 5'd0);
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rr_ptr_q   <= PTR_FIRST;
      wait_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign rf_wr_en_o   = wr_en_q;
  assign rf_wr_addr_o = wr_addr_q;
  assign rf_wr_data_o = wr_data_q;

endmodule

`default_nettype wire
